// File: rtl/sargantana_itag_lookup.sv
// I-cache tag block: tag/valid/tree-PLRU storage with registered lookup result,
// victim selection, single-line invalidate and a set-walking init/flush engine.
module sargantana_itag_lookup #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_DEPTH      = 64,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  output logic                      ready_o,
  input  logic                      lookup_valid_i,
  input  logic [TAG_ADDR_WIDHT-1:0] lookup_addr_i,
  input  logic [TAG_WIDHT-1:0]      lookup_tag_i,
  output logic                      hit_valid_o,
  output logic                      hit_o,
  output logic [ICACHE_N_WAY-1:0]   hit_way_o,
  output logic [ICACHE_N_WAY-1:0]   victim_way_o,
  input  logic                      fill_valid_i,
  input  logic [TAG_ADDR_WIDHT-1:0] fill_addr_i,
  input  logic [ICACHE_N_WAY-1:0]   fill_way_i,
  input  logic [TAG_WIDHT-1:0]      fill_tag_i,
  input  logic                      inval_valid_i,
  input  logic [TAG_ADDR_WIDHT-1:0] inval_addr_i,
  input  logic [TAG_WIDHT-1:0]      inval_tag_i
);

  localparam int LOG_WAY = $clog2(ICACHE_N_WAY);
  localparam int PLRU_W  = ICACHE_N_WAY - 1;
  localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [TAG_WIDHT-1:0]    tag_mem   [TAG_DEPTH][ICACHE_N_WAY];
  logic [ICACHE_N_WAY-1:0] valid_mem [TAG_DEPTH];
  logic [PLRU_W-1:0]       plru_mem  [TAG_DEPTH];

  logic [1:0]                state;
  logic [TAG_ADDR_WIDHT-1:0] counter;
  logic                      ready_q;

  function automatic logic [LOG_WAY-1:0] onehot_to_idx(input logic [ICACHE_N_WAY-1:0] oh);
    logic [LOG_WAY-1:0] idx;
    idx = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++)
      if (oh[w]) idx = idx | LOG_WAY'(w);
    return idx;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1).
  // A bit points toward the side the next victim comes from.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [ICACHE_N_WAY-1:0] way_oh);
    logic [PLRU_W-1:0]  res;
    logic [PLRU_W-1:0]  mask;
    logic [LOG_WAY-1:0] idx;
    logic               dir;
    int                 node;
    res  = bits;
    idx  = onehot_to_idx(way_oh);
    node = 0;
    for (int l = 0; l < LOG_WAY; l++) begin
      dir  = idx[LOG_WAY-1-l];
      mask = PLRU_W'(1) << node;
      if (dir) res = res & ~mask;
      else     res = res | mask;
      node = 2 * node + 1 + int'(dir);
    end
    return res;
  endfunction

  function automatic logic [ICACHE_N_WAY-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [PLRU_W-1:0] sh;
    int                node;
    node = 0;
    for (int l = 0; l < LOG_WAY; l++) begin
      sh   = bits >> node;
      node = 2 * node + 1 + int'(sh[0]);
    end
    return ICACHE_N_WAY'(1) << (node - PLRU_W);
  endfunction

  function automatic logic [ICACHE_N_WAY-1:0] lowest_invalid(input logic [ICACHE_N_WAY-1:0] vld);
    logic [ICACHE_N_WAY-1:0] res;
    res = '0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--)
      if (!vld[w]) res = ICACHE_N_WAY'(1) << w;
    return res;
  endfunction

  logic                    accept, lk_acc, fill_acc, inval_acc, lk_hit_acc;
  logic [ICACHE_N_WAY-1:0] lk_valid, lk_match, inv_match, victim;
  logic [ICACHE_N_WAY-1:0] valid_after_inval, valid_after_fill;
  logic [PLRU_W-1:0]       plru_lk_new, plru_fill_base, plru_fill_new;

  always_comb begin
    accept     = ready_q & ~flush_i;
    lk_acc     = accept & lookup_valid_i;
    fill_acc   = accept & fill_valid_i;
    inval_acc  = accept & inval_valid_i;
    lk_valid   = valid_mem[lookup_addr_i];
    lk_match   = '0;
    inv_match  = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      lk_match[w]  = lk_valid[w] && (tag_mem[lookup_addr_i][w] == lookup_tag_i);
      inv_match[w] = valid_mem[inval_addr_i][w] && (tag_mem[inval_addr_i][w] == inval_tag_i);
    end
    lk_hit_acc = lk_acc & (|lk_match);
    victim     = (&lk_valid) ? plru_victim(plru_mem[lookup_addr_i]) : lowest_invalid(lk_valid);

    valid_after_inval = valid_mem[inval_addr_i] & ~inv_match;
    // Fill wins over an invalidate of the same set: apply the inval first, then set the fill way.
    valid_after_fill  = ((inval_acc && (inval_addr_i == fill_addr_i)) ? valid_after_inval
                                                                       : valid_mem[fill_addr_i])
                        | fill_way_i;

    plru_lk_new    = plru_touch(plru_mem[lookup_addr_i], lk_match);
    plru_fill_base = (lk_hit_acc && (fill_addr_i == lookup_addr_i)) ? plru_lk_new
                                                                     : plru_mem[fill_addr_i];
    plru_fill_new  = plru_touch(plru_fill_base, fill_way_i);
  end

  always_ff @(posedge clk_i) begin
    if (state != ST_IDLE) begin
      valid_mem[counter] <= '0;
      plru_mem[counter]  <= '0;
    end else begin
      if (inval_acc)  valid_mem[inval_addr_i]  <= valid_after_inval;
      if (fill_acc)   valid_mem[fill_addr_i]   <= valid_after_fill;
      if (lk_hit_acc) plru_mem[lookup_addr_i]  <= plru_lk_new;
      if (fill_acc)   plru_mem[fill_addr_i]    <= plru_fill_new;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < ICACHE_N_WAY; w++)
      if (fill_acc && fill_way_i[w]) tag_mem[fill_addr_i][w] <= fill_tag_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_INIT;
      counter <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_FLUSH: begin
          if (counter == LAST_SET) begin
            state   <= ST_IDLE;
            counter <= '0;
            ready_q <= 1'b1;
          end else begin
            counter <= counter + TAG_ADDR_WIDHT'(1);
          end
        end
        ST_IDLE: begin
          if (flush_i) begin
            state   <= ST_FLUSH;
            counter <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          counter <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: registered lookup result, valid one cycle after accept
  logic                    vld_p1, hit_p1;
  logic [ICACHE_N_WAY-1:0] hit_way_p1, victim_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      hit_p1     <= 1'b0;
      hit_way_p1 <= '0;
      victim_p1  <= '0;
    end else begin
      vld_p1 <= lk_acc;
      if (lk_acc) begin
        hit_p1     <= |lk_match;
        hit_way_p1 <= lk_match;
        victim_p1  <= victim;
      end
    end
  end

  assign ready_o      = ready_q;
  assign hit_valid_o  = vld_p1;
  assign hit_o        = hit_p1;
  assign hit_way_o    = hit_way_p1;
  assign victim_way_o = victim_p1;

endmodule

// File: tb/tb_sargantana_itag_lookup.sv
// Scoreboard bench for sargantana_itag_lookup: expected lookup results are queued
// at issue time and compared when hit_valid_o appears.
module tb_sargantana_itag_lookup;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        ready_o;
  logic        lookup_valid_i;
  logic [5:0]  lookup_addr_i;
  logic [19:0] lookup_tag_i;
  logic        hit_valid_o;
  logic        hit_o;
  logic [3:0]  hit_way_o;
  logic [3:0]  victim_way_o;
  logic        fill_valid_i;
  logic [5:0]  fill_addr_i;
  logic [3:0]  fill_way_i;
  logic [19:0] fill_tag_i;
  logic        inval_valid_i;
  logic [5:0]  inval_addr_i;
  logic [19:0] inval_tag_i;

  sargantana_itag_lookup #(
    .ICACHE_N_WAY(4), .TAG_DEPTH(64), .TAG_ADDR_WIDHT(6), .TAG_WIDHT(20)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ready_o(ready_o),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i), .lookup_tag_i(lookup_tag_i),
    .hit_valid_o(hit_valid_o), .hit_o(hit_o), .hit_way_o(hit_way_o), .victim_way_o(victim_way_o),
    .fill_valid_i(fill_valid_i), .fill_addr_i(fill_addr_i), .fill_way_i(fill_way_i),
    .fill_tag_i(fill_tag_i), .inval_valid_i(inval_valid_i), .inval_addr_i(inval_addr_i),
    .inval_tag_i(inval_tag_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       hit;
    logic [3:0] way;
    logic [3:0] vic;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (hit_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_hit_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_hit"},    {31'd0, hit_o},   {31'd0, mon_e.hit});
        check({mon_e.name, "_way"},    {28'd0, hit_way_o},    {28'd0, mon_e.way});
        check({mon_e.name, "_victim"}, {28'd0, victim_way_o}, {28'd0, mon_e.vic});
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (lookup_valid_i || fill_valid_i || inval_valid_i)
        assert (ready_o && !flush_i) else $error("request issued while block busy");
      if (hit_valid_o)
        assert ($onehot0(hit_way_o)) else $error("more than one way matched");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_lookup(input logic [5:0] a, input logic [19:0] t, input logic h,
                           input logic [3:0] w, input logic [3:0] v, input string nm);
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_addr_i = a; lookup_tag_i = t;
    sb.push_back('{hit: h, way: w, vic: v, name: nm});
    @(negedge clk_i);
    lookup_valid_i = 1'b0;
  endtask

  task automatic do_fill(input logic [5:0] a, input logic [3:0] w, input logic [19:0] t);
    @(negedge clk_i);
    fill_valid_i = 1'b1; fill_addr_i = a; fill_way_i = w; fill_tag_i = t;
    @(negedge clk_i);
    fill_valid_i = 1'b0;
  endtask

  task automatic do_inval(input logic [5:0] a, input logic [19:0] t);
    @(negedge clk_i);
    inval_valid_i = 1'b1; inval_addr_i = a; inval_tag_i = t;
    @(negedge clk_i);
    inval_valid_i = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk_i);
      cnt++;
      #1;
      if (ready_o) break;
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    lookup_valid_i = 1'b0; lookup_addr_i = '0; lookup_tag_i = '0;
    fill_valid_i = 1'b0; fill_addr_i = '0; fill_way_i = '0; fill_tag_i = '0;
    inval_valid_i = 1'b0; inval_addr_i = '0; inval_tag_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_hit_valid", {31'd0, hit_valid_o}, 32'd0);
    check("rst_hit", {31'd0, hit_o}, 32'd0);
    check("rst_hit_way", {28'd0, hit_way_o}, 32'd0);
    check("rst_victim", {28'd0, victim_way_o}, 32'd0);
    rst_i = 1'b0;
    wait_ready(n);
    check("init_walk_cycles", n, 64);

    do_lookup(6'd5, 20'h123, 1'b0, 4'b0000, 4'b0001, "cold_miss");
    for (int w = 0; w < 4; w++) do_fill(6'd5, 4'b0001 << w, 20'hA0 + 20'(w));
    do_lookup(6'd5, 20'hA2, 1'b1, 4'b0100, 4'b0001, "hit_a2");

    do_lookup(6'd5, 20'hA0, 1'b1, 4'b0001, 4'b0001, "seq_hit0");
    do_lookup(6'd5, 20'hA1, 1'b1, 4'b0010, 4'b1000, "seq_hit1");
    do_lookup(6'd5, 20'hA2, 1'b1, 4'b0100, 4'b1000, "seq_hit2");
    do_lookup(6'd5, 20'hA3, 1'b1, 4'b1000, 4'b0001, "seq_hit3");
    do_lookup(6'd5, 20'h123, 1'b0, 4'b0000, 4'b0001, "plru_vic0");
    do_lookup(6'd5, 20'hA0, 1'b1, 4'b0001, 4'b0001, "touch_w0");
    do_lookup(6'd5, 20'h123, 1'b0, 4'b0000, 4'b0100, "plru_vic2");

    do_inval(6'd5, 20'hA1);
    do_lookup(6'd5, 20'hA1, 1'b0, 4'b0000, 4'b0010, "inval_a1");
    do_fill(6'd5, 4'b0010, 20'hA1);
    do_inval(6'd5, 20'hFF);
    do_lookup(6'd5, 20'hA1, 1'b1, 4'b0010, 4'b0100, "nomatch_a1");
    do_lookup(6'd5, 20'hA3, 1'b1, 4'b1000, 4'b0100, "nomatch_a3");
    do_lookup(6'd5, 20'hA0, 1'b1, 4'b0001, 4'b0001, "nomatch_a0");
    do_lookup(6'd5, 20'hA2, 1'b1, 4'b0100, 4'b0100, "nomatch_a2");

    // Fill and lookup in the same cycle: lookup sees the old tag
    @(negedge clk_i);
    fill_valid_i = 1'b1; fill_addr_i = 6'd5; fill_way_i = 4'b0001; fill_tag_i = 20'hB0;
    lookup_valid_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 20'hB0;
    sb.push_back('{hit: 1'b0, way: 4'b0000, vic: 4'b0010, name: "fill_lookup_same"});
    @(negedge clk_i);
    fill_valid_i = 1'b0; lookup_valid_i = 1'b0;
    do_lookup(6'd5, 20'hB0, 1'b1, 4'b0001, 4'b1000, "after_fill_b0");

    @(negedge clk_i);
    fill_valid_i = 1'b1; fill_addr_i = 6'd5; fill_way_i = 4'b0100; fill_tag_i = 20'hC2;
    inval_valid_i = 1'b1; inval_addr_i = 6'd5; inval_tag_i = 20'hA2;
    @(negedge clk_i);
    fill_valid_i = 1'b0; inval_valid_i = 1'b0;
    do_lookup(6'd5, 20'hC2, 1'b1, 4'b0100, 4'b0010, "fill_beats_inval");
    do_lookup(6'd6, 20'hA0, 1'b0, 4'b0000, 4'b0001, "other_set");

    // Lookup in the cycle before flush still returns pre-flush contents
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 20'hB0;
    sb.push_back('{hit: 1'b1, way: 4'b0001, vic: 4'b0010, name: "pre_flush"});
    @(negedge clk_i);
    lookup_valid_i = 1'b0; flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    check("flush_ready_drop", {31'd0, ready_o}, 32'd0);
    wait_ready(n);
    check("flush_walk_cycles", n, 64);
    do_lookup(6'd5, 20'hB0, 1'b0, 4'b0000, 4'b0001, "flushed_b0");
    do_lookup(6'd5, 20'hA1, 1'b0, 4'b0000, 4'b0001, "flushed_a1");
    do_lookup(6'd5, 20'hC2, 1'b0, 4'b0000, 4'b0001, "flushed_c2");

    // Reset with a lookup result on the outputs, then again mid-walk
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 20'h0;
    @(posedge clk_i);
    #1 lookup_valid_i = 1'b0;
    check("inflight_hit_valid", {31'd0, hit_valid_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("async_rst_hit_valid", {31'd0, hit_valid_o}, 32'd0);
    check("async_rst_victim", {28'd0, victim_way_o}, 32'd0);
    check("async_rst_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (30) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1 check("midwalk_rst_ready", {31'd0, ready_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    wait_ready(n);
    check("rst_restart_cycles", n, 64);
    do_lookup(6'd5, 20'hB0, 1'b0, 4'b0000, 4'b0001, "post_rst");

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
